// File: rtl/divider_seq_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
// The master side issues start with operands; the slave side is the divider.
interface divider_seq_if #(
    parameter int W = 2
);
    logic              start;
    logic [2*W-1:0]    dividend;
    logic [W-1:0]      divisor;
    logic              ready;
    logic              busy;
    logic              done;
    logic [2*W-1:0]    quotient;
    logic [W-1:0]      remainder;
    logic              div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  ready,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output ready,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/divider_seq.sv
// Multi-cycle restoring unsigned divider: a 2*W-bit dividend over a W-bit
// divisor, one quotient bit per clock, with a start/done handshake.
// The dividend register doubles as the quotient register: each step shifts
// one dividend bit out of the top and one quotient bit in at the bottom.
module divider_seq #(
    parameter int W = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    divider_seq_if.slave  bus
);
    localparam int QW = 2 * W;
    localparam int CW = $clog2(QW + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]     r_state;
    logic [QW-1:0]  r_shiftReg;
    logic [W-1:0]   r_divisor;
    logic [W-1:0]   r_partRem;
    logic [CW-1:0]  r_count;
    logic [QW-1:0]  r_quotient;
    logic [W-1:0]   r_remainder;
    logic           r_divByZero;
    logic           r_ready;
    logic           r_busy;
    logic           r_done;

    logic [W:0]     w_shifted;
    logic [W+1:0]   w_trial;
    logic           w_qBit;
    logic [W:0]     w_nextRem;
    logic [QW-1:0]  w_nextShift;
    logic           w_lastStep;

    // One restoring step. The shifted partial remainder is W+1 bits wide; only
    // its low W bits are kept between steps because after the restore decision
    // it is always below a non-zero divisor, and with a zero divisor the top
    // bit is shifted out on the next step anyway. The trial subtraction carries
    // an extra borrow bit so a zero divisor never looks negative, which makes
    // divide-by-zero naturally produce an all-ones quotient.
    always_comb begin
        w_shifted   = {r_partRem, r_shiftReg[QW-1]};
        w_trial     = {1'b0, w_shifted} - {2'b00, r_divisor};
        w_qBit      = ~w_trial[W+1];
        w_nextRem   = w_qBit ? w_trial[W:0] : w_shifted;
        w_nextShift = {r_shiftReg[QW-2:0], w_qBit};
        w_lastStep  = (r_count == CW'(1));
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shiftReg  <= '0;
            r_divisor   <= '0;
            r_partRem   <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_divByZero <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_shiftReg  <= bus.dividend;
                        r_divisor   <= bus.divisor;
                        r_partRem   <= '0;
                        r_count     <= CW'(QW);
                        r_divByZero <= 1'b0;
                        r_ready     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_shiftReg <= w_nextShift;
                    r_partRem  <= w_nextRem[W-1:0];
                    r_count    <= r_count - CW'(1);
                    if (w_lastStep) begin
                        r_quotient  <= w_nextShift;
                        r_remainder <= w_nextRem[W-1:0];
                        r_divByZero <= (r_divisor == '0);
                        r_done      <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready       = r_ready;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_divByZero;
endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed cases, a held-start stream,
// a mid-calculation reset, the multiplier round trip and random operands,
// all checked against plain integer division.
module tb_divider_seq;
    localparam int W  = 2;
    localparam int QW = 2 * W;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    divider_seq_if #(.W(W)) bus ();

    divider_seq #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] time limit reached");
    end

    function automatic int refQuot(input int dvd, input int dvs);
        if (dvs == 0) return (1 << QW) - 1;
        return dvd / dvs;
    endfunction

    function automatic int refRem(input int dvd, input int dvs);
        if (dvs == 0) return dvd % (1 << W);
        return dvd % dvs;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one full division and checks handshake, latency and results.
    task automatic applyStimulus(input int dvd, input int dvs);
        int cycles;
        cycles = 0;
        while (!bus.ready && cycles < 20) begin
            tick();
            cycles++;
        end
        checkOutput("ready before start", int'(bus.ready), 1);
        bus.start    = 1'b1;
        bus.dividend = QW'(dvd);
        bus.divisor  = W'(dvs);
        tick();
        bus.start    = 1'b0;
        bus.dividend = QW'($urandom);
        bus.divisor  = W'($urandom);
        checkOutput("ready after accept", int'(bus.ready), 0);
        checkOutput("busy after accept", int'(bus.busy), 1);
        checkOutput("dbz cleared on accept", int'(bus.div_by_zero), 0);
        cycles = 0;
        while (!bus.done && cycles < 20) begin
            tick();
            cycles++;
        end
        checkOutput("latency", cycles, QW);
        checkOutput("quotient", int'(bus.quotient), refQuot(dvd, dvs));
        checkOutput("remainder", int'(bus.remainder), refRem(dvd, dvs));
        checkOutput("div_by_zero", int'(bus.div_by_zero), (dvs == 0) ? 1 : 0);
        tick();
        checkOutput("done one cycle", int'(bus.done), 0);
        checkOutput("ready after done", int'(bus.ready), 1);
    endtask

    initial begin
        int qDvd[$];
        int qDvs[$];
        int doneCount;
        int lastDone;
        int seen;
        int dvdNow;
        int dvsNow;
        int expDvd;
        int expDvs;

        checks       = 0;
        errors       = 0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("reset ready", int'(bus.ready), 1);
        checkOutput("reset busy", int'(bus.busy), 0);
        checkOutput("reset done", int'(bus.done), 0);
        checkOutput("reset quotient", int'(bus.quotient), 0);
        checkOutput("reset remainder", int'(bus.remainder), 0);
        checkOutput("reset dbz", int'(bus.div_by_zero), 0);

        $display("[TB] directed cases");
        applyStimulus(6, 2);
        applyStimulus(9, 2);
        applyStimulus(15, 1);
        applyStimulus(15, 3);
        applyStimulus(13, 0);
        applyStimulus(6, 3);
        applyStimulus(0, 0);
        applyStimulus(15, 0);

        $display("[TB] start held high with changing operands");
        doneCount = 0;
        lastDone  = -1;
        bus.start = 1'b1;
        for (int i = 0; i < 36; i++) begin
            if (bus.done) begin
                if (qDvd.size() == 0) begin
                    checkOutput("hold unexpected done", 1, 0);
                end else begin
                    expDvd = qDvd.pop_front();
                    expDvs = qDvs.pop_front();
                    checkOutput("hold quotient", int'(bus.quotient), refQuot(expDvd, expDvs));
                    checkOutput("hold remainder", int'(bus.remainder), refRem(expDvd, expDvs));
                    checkOutput("hold dbz", int'(bus.div_by_zero), (expDvs == 0) ? 1 : 0);
                end
                if (lastDone >= 0) checkOutput("hold spacing", i - lastDone, QW + 2);
                lastDone = i;
                doneCount++;
            end
            dvdNow       = $urandom_range(0, (1 << QW) - 1);
            dvsNow       = $urandom_range(0, (1 << W) - 1);
            bus.dividend = QW'(dvdNow);
            bus.divisor  = W'(dvsNow);
            if (bus.ready) begin
                qDvd.push_back(dvdNow);
                qDvs.push_back(dvsNow);
            end
            tick();
        end
        bus.start = 1'b0;
        checkOutput("hold done count", doneCount, 6);
        checkOutput("hold pending results", qDvd.size(), 0);

        $display("[TB] reset during calculation");
        applyStimulus(9, 2);
        bus.start    = 1'b1;
        bus.dividend = QW'(14);
        bus.divisor  = W'(3);
        tick();
        bus.start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("abort ready", int'(bus.ready), 1);
        checkOutput("abort busy", int'(bus.busy), 0);
        checkOutput("abort done", int'(bus.done), 0);
        checkOutput("abort quotient", int'(bus.quotient), 0);
        checkOutput("abort remainder", int'(bus.remainder), 0);
        seen = 0;
        repeat (8) begin
            tick();
            if (bus.done) seen++;
        end
        checkOutput("abort no done", seen, 0);
        applyStimulus(14, 3);

        $display("[TB] multiplier round trip");
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 1; b < (1 << W); b++) begin
                applyStimulus(a * b, b);
                checkOutput("round trip a", int'(bus.quotient), a);
            end
        end

        $display("[TB] random operands");
        for (int n = 0; n < 1000; n++) begin
            applyStimulus($urandom_range(0, (1 << QW) - 1), $urandom_range(1, (1 << W) - 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
